// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the fetch PC and the IF/ID and ID/EX control strobes. Converts
//   load-use stall requests and branch decode/resolve events into PC holds,
//   IF/ID flushes, ID/EX bubbles and branch redirects.
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   hold_req        load-use hazard for the instruction in ID
//   branch_dec      beq/bne in ID this cycle
//   branch_resolve  branch outcome valid from EX this cycle
//   branch_taken    branch outcome, qualified by branch_resolve
//   branch_offset   sign-extended word offset, qualified by branch_resolve
//   pc              current fetch address (registered)
//   pc_write        PC advances this cycle
//   if_id_write     IF/ID register loads this cycle
//   if_id_flush     IF/ID register loads a NOP this cycle
//   id_ex_bubble    ID/EX control fields zeroed this cycle
//   stall_cycles    saturating count of cycles with pc_write=0 since reset
//   br_timeout_err  sticky flag, set when a branch wait times out
//
// Handshake: there is no valid/ready pair here. Each strobe is a single-cycle
// qualifier that is only meaningful in the cycle it is asserted; the IF and
// ID stages act on it at the next rising edge, with no back-pressure.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC          = 32'h0000_0000,
  parameter int          LOAD_STALL_CYCLES = 1,
  parameter int          BR_TIMEOUT        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_req,
  input  logic        branch_dec,
  input  logic        branch_resolve,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic [15:0] stall_cycles,
  output logic        br_timeout_err
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_WAIT    = 2'd2
  } state_t;

  localparam logic [2:0] STALL_LOAD = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [7:0] TMO_LAST   = 8'(BR_TIMEOUT - 1);

  state_t      state;
  logic [31:0] br_base;
  logic [2:0]  cnt;
  logic [7:0]  tmo;
  logic        br_expire;

  assign br_expire = (tmo == TMO_LAST);

  // Strobes are decoded from the current state and inputs; all are forced
  // low while reset is asserted.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (hold_req) begin
            id_ex_bubble = 1'b1;
          end else if (branch_dec) begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
        LOAD_STALL: begin
          id_ex_bubble = 1'b1;
        end
        BR_WAIT: begin
          if (branch_resolve && branch_taken) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end else if (branch_resolve || br_expire) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end else begin
            if_id_write = 1'b1;
            if_id_flush = 1'b1;
          end
        end
        default: begin
          pc_write = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      pc             <= RESET_PC;
      br_base        <= RESET_PC;
      cnt            <= 3'd0;
      tmo            <= 8'd0;
      stall_cycles   <= 16'd0;
      br_timeout_err <= 1'b0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
      case (state)
        RUN: begin
          if (hold_req) begin
            // A branch_dec in the same cycle is dropped; the branch stays in
            // ID and re-asserts branch_dec when the stall is over.
            if (LOAD_STALL_CYCLES > 1) begin
              state <= LOAD_STALL;
              cnt   <= STALL_LOAD;
            end
          end else if (branch_dec) begin
            br_base <= pc;
            tmo     <= 8'd0;
            state   <= BR_WAIT;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        LOAD_STALL: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RUN;
          end
        end
        BR_WAIT: begin
          if (branch_resolve && branch_taken) begin
            // Word offset scaled to bytes; the top two offset bits fall off
            // the shift and the sum wraps modulo 2^32.
            pc    <= br_base + (branch_offset << 2);
            state <= RUN;
          end else if (branch_resolve) begin
            pc    <= pc + 32'd4;
            state <= RUN;
          end else if (br_expire) begin
            // Forced not-taken recovery; a resolve in this same cycle would
            // have been taken above and would not flag the error.
            pc             <= pc + 32'd4;
            br_timeout_err <= 1'b1;
            state          <= RUN;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//   Randomized and directed stimulus for pc_sequencer. Each driven cycle the
//   reference model's expected outputs are queued; a negedge monitor pops and
//   compares them against the DUT.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          LSC      = 2;
  localparam int          BRT      = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n          = 1'b0;
  logic        hold_req       = 1'b0;
  logic        branch_dec     = 1'b0;
  logic        branch_resolve = 1'b0;
  logic        branch_taken   = 1'b0;
  logic [31:0] branch_offset  = 32'd0;
  logic [31:0] pc;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic [15:0] stall_cycles;
  logic        br_timeout_err;

  pc_sequencer #(
    .RESET_PC(RESET_PC),
    .LOAD_STALL_CYCLES(LSC),
    .BR_TIMEOUT(BRT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hold_req(hold_req),
    .branch_dec(branch_dec),
    .branch_resolve(branch_resolve),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .pc(pc),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .stall_cycles(stall_cycles),
    .br_timeout_err(br_timeout_err)
  );

  // ---------------- scoreboard ----------------
  // {pc[31:0], pc_write, if_id_write, if_id_flush, id_ex_bubble, stall[15:0], err}
  logic [52:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view: remaining bubble cycles, whether a branch is pending and
  // how many wait cycles it has aged, plus the architectural counters.
  logic [31:0] m_pc          = RESET_PC;
  logic [31:0] m_base        = RESET_PC;
  int          m_stall_left  = 0;
  bit          m_pending     = 1'b0;
  int          m_age         = 0;
  int          m_sc          = 0;
  bit          m_err         = 1'b0;
  bit          model_valid   = 1'b0;

  // Drives one cycle of inputs, queues the expected outputs for that cycle,
  // then advances the model to the state after the next rising edge.
  task automatic drive(input logic rn, input logic h, input logic d,
                       input logic r, input logic t, input logic [31:0] off);
    logic e_pw, e_iw, e_fl, e_bub;
    @(posedge clk);
    #1;
    rst_n = rn; hold_req = h; branch_dec = d;
    branch_resolve = r; branch_taken = t; branch_offset = off;
    e_pw = 1'b0; e_iw = 1'b0; e_fl = 1'b0; e_bub = 1'b0;
    if (rn) begin
      if (m_stall_left > 0) begin
        e_bub = 1'b1;
      end else if (m_pending) begin
        if (r && t) begin
          e_pw = 1'b1; e_iw = 1'b1; e_fl = 1'b1;
        end else if (r || m_age == BRT - 1) begin
          e_pw = 1'b1; e_iw = 1'b1;
        end else begin
          e_iw = 1'b1; e_fl = 1'b1;
        end
      end else if (h) begin
        e_bub = 1'b1;
      end else if (d) begin
        e_iw = 1'b1; e_fl = 1'b1;
      end else begin
        e_pw = 1'b1; e_iw = 1'b1;
      end
    end
    if (model_valid) begin
      exp_q.push_back({m_pc, e_pw, e_iw, e_fl, e_bub, 16'(m_sc), m_err});
    end
    if (!rn) begin
      m_pc = RESET_PC; m_stall_left = 0; m_pending = 1'b0; m_age = 0;
      m_sc = 0; m_err = 1'b0; model_valid = 1'b1;
    end else begin
      if (!e_pw && m_sc < 65535) m_sc++;
      if (m_stall_left > 0) begin
        m_stall_left--;
      end else if (m_pending) begin
        if (r && t) begin
          m_pc = m_base + off * 32'd4;
          m_pending = 1'b0;
        end else if (r) begin
          m_pc = m_pc + 32'd4;
          m_pending = 1'b0;
        end else if (m_age == BRT - 1) begin
          m_pc = m_pc + 32'd4;
          m_err = 1'b1;
          m_pending = 1'b0;
        end else begin
          m_age++;
        end
      end else if (h) begin
        m_stall_left = LSC - 1;
      end else if (d) begin
        m_base = m_pc; m_age = 0; m_pending = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 32'd0);
  endtask

  // ---------------- monitor ----------------
  logic [52:0] mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("pc",             pc,                     mon_e[52:21]);
      check("pc_write",       {31'd0, pc_write},      {31'd0, mon_e[20]});
      check("if_id_write",    {31'd0, if_id_write},   {31'd0, mon_e[19]});
      check("if_id_flush",    {31'd0, if_id_flush},   {31'd0, mon_e[18]});
      check("id_ex_bubble",   {31'd0, id_ex_bubble},  {31'd0, mon_e[17]});
      check("stall_cycles",   {16'd0, stall_cycles},  {16'd0, mon_e[16:1]});
      check("br_timeout_err", {31'd0, br_timeout_err}, {31'd0, mon_e[0]});
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(0, 0, 0, 0, 0, 32'd0);
    drive(0, 0, 0, 0, 0, 32'd0);
    idle(2);                                 // pc 0, 4
    drive(1, 1, 0, 0, 0, 32'd0);             // hold at pc 8
    drive(1, 1, 0, 0, 0, 32'd0);             // stall cycle, hold ignored
    idle(3);                                 // pc 8, 12, 16
    drive(1, 0, 1, 0, 0, 32'd0);             // branch_dec at pc 20
    drive(1, 0, 0, 0, 0, 32'd0);             // wait
    drive(1, 0, 0, 1, 1, 32'd3);             // taken -> 32
    drive(1, 0, 1, 0, 0, 32'd0);             // branch_dec at 32
    drive(1, 1, 1, 0, 0, 32'd0);             // wait, hold/dec ignored
    drive(1, 0, 0, 1, 0, 32'd9);             // not taken -> 36
    drive(1, 0, 0, 1, 1, 32'd100);           // resolve in RUN ignored -> 40
    drive(1, 1, 1, 0, 0, 32'd0);             // hold wins over dec
    drive(1, 0, 0, 0, 0, 32'd0);             // stall cycle
    drive(1, 0, 1, 0, 0, 32'd0);             // dec re-asserted at 40
    idle(3);                                 // tmo 0,1,2
    drive(1, 0, 0, 1, 0, 32'd0);             // resolve at timeout cycle, no err
    idle(1);
    drive(0, 0, 0, 0, 0, 32'd0);             // reset
    idle(2);                                 // pc 0, 4
    drive(1, 0, 1, 0, 0, 32'd0);             // dec at 8
    drive(1, 0, 0, 1, 1, 32'hFFFF_FFFC);     // -> FFFF_FFF8
    idle(1);
    drive(1, 0, 1, 0, 0, 32'd0);             // dec, then time out
    idle(6);
    drive(1, 0, 1, 0, 0, 32'd0);             // dec, reset mid-wait
    idle(1);
    drive(0, 0, 0, 0, 0, 32'd0);
    idle(3);
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)),
            $urandom);
    end
    idle(2);
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
